seven_segment_capture: RTL

- Receiving end of the multiplexed 6-digit seven-segment bus (fnd_pos/fnd_data) driven by the board's display scanner.
- Samples the bus, decodes each segment pattern back to the 4-bit display code, and reassembles the 24-bit display word per complete scan frame.
- Detects blink-off (blank) intervals.
- Used as the loopback/self-test monitor and as a checker on the final-project board.

---
 rtl/seg_pkg.sv | 67 ++++++
 rtl/seven_segment_capture_if.sv | 13 +
 rtl/seg_pattern_decode.sv | 36 +++
 rtl/seven_segment_capture.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment code, pattern and digit-select constants
//
// Purpose: one table of display codes, segment patterns and fnd_pos one-hot
//          values, shared by the display scanner and the capture monitor.
// Ports:   none (package).
package seg_pkg;

   // 4-bit display codes
   localparam logic [3:0] SN = 4'd0;   // blank
   localparam logic [3:0] SA = 4'd1;
   localparam logic [3:0] SS = 4'd2;
   localparam logic [3:0] S0 = 4'd3;
   localparam logic [3:0] S1 = 4'd4;
   localparam logic [3:0] S2 = 4'd5;
   localparam logic [3:0] S3 = 4'd6;
   localparam logic [3:0] S4 = 4'd7;
   localparam logic [3:0] S5 = 4'd8;
   localparam logic [3:0] S6 = 4'd9;
   localparam logic [3:0] S7 = 4'd10;
   localparam logic [3:0] S8 = 4'd11;
   localparam logic [3:0] S9 = 4'd12;
   localparam logic [3:0] SX = 4'd15;  // undecodable pattern

   // Segment patterns, bit7..bit0 = a,b,c,d,e,f,g,dp
   localparam logic [7:0] PAT_N = 8'b0000_0000;
   localparam logic [7:0] PAT_A = 8'b1100_0110;
   localparam logic [7:0] PAT_S = 8'b0011_1010;
   localparam logic [7:0] PAT_0 = 8'b1111_1100;
   localparam logic [7:0] PAT_1 = 8'b0110_0000;
   localparam logic [7:0] PAT_2 = 8'b1101_1010;
   localparam logic [7:0] PAT_3 = 8'b1111_0010;
   localparam logic [7:0] PAT_4 = 8'b0110_0110;
   localparam logic [7:0] PAT_5 = 8'b1011_0110;
   localparam logic [7:0] PAT_6 = 8'b1011_1110;
   localparam logic [7:0] PAT_7 = 8'b1110_0100;
   localparam logic [7:0] PAT_8 = 8'b1111_1110;
   localparam logic [7:0] PAT_9 = 8'b1111_0110;

   // Active-low one-hot digit selects; digit0 is the leftmost digit
   localparam logic [5:0] POS_D0  = 6'b011111;
   localparam logic [5:0] POS_D1  = 6'b101111;
   localparam logic [5:0] POS_D2  = 6'b110111;
   localparam logic [5:0] POS_D3  = 6'b111011;
   localparam logic [5:0] POS_D4  = 6'b111101;
   localparam logic [5:0] POS_D5  = 6'b111110;
   localparam logic [5:0] POS_OFF = 6'b111111;

   // Scanner-side encode; seg_pattern_decode is its exact inverse.
   function automatic logic [7:0] seg_encode(input logic [3:0] code);
      case (code)
         SA:      return PAT_A;
         SS:      return PAT_S;
         S0:      return PAT_0;
         S1:      return PAT_1;
         S2:      return PAT_2;
         S3:      return PAT_3;
         S4:      return PAT_4;
         S5:      return PAT_5;
         S6:      return PAT_6;
         S7:      return PAT_7;
         S8:      return PAT_8;
         S9:      return PAT_9;
         default: return PAT_N;
      endcase
   endfunction

endpackage

// File: rtl/seven_segment_capture_if.sv
// rtl/seven_segment_capture_if.sv - multiplexed seven-segment bus
//
// Purpose: digit-select plus segment-pattern bus between scanner and capture.
// Signals: fnd_pos  [5:0] active-low one-hot digit select, 6'b111111 = all off
//          fnd_data [7:0] segment pattern a..g,dp, valid with fnd_pos
// Modports: master = scanner (drives), slave = capture (samples).
interface seven_segment_capture_if;
   logic [5:0] fnd_pos;
   logic [7:0] fnd_data;

   modport master (output fnd_pos, output fnd_data);
   modport slave  (input  fnd_pos, input  fnd_data);
endinterface

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - segment pattern to display code decoder
//
// Purpose: combinational inverse of seg_encode.
// Ports:   pat_i     [7:0] segment pattern
//          code_o    [3:0] display code, SX for an unknown pattern
//          invalid_o       high when pat_i is not in the table
module seg_pattern_decode
   import seg_pkg::*;
(
   input  logic [7:0] pat_i,
   output logic [3:0] code_o,
   output logic       invalid_o
);

   always_comb begin
      code_o    = SX;
      invalid_o = 1'b0;
      case (pat_i)
         PAT_N:   code_o = SN;
         PAT_A:   code_o = SA;
         PAT_S:   code_o = SS;
         PAT_0:   code_o = S0;
         PAT_1:   code_o = S1;
         PAT_2:   code_o = S2;
         PAT_3:   code_o = S3;
         PAT_4:   code_o = S4;
         PAT_5:   code_o = S5;
         PAT_6:   code_o = S6;
         PAT_7:   code_o = S7;
         PAT_8:   code_o = S8;
         PAT_9:   code_o = S9;
         default: invalid_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/seven_segment_capture.sv
// rtl/seven_segment_capture.sv - seven-segment bus capture and frame checker
//
// Purpose: samples the scanner bus, decodes each digit, rebuilds the 24-bit
//          display word per in-order scan frame and tracks blink intervals.
// Ports:   clk, rst_n       clock, asynchronous active-low reset
//          bus (slave)      fnd_pos / fnd_data from the scanner
//          display [23:0]   last committed frame, digit0 in [23:20]
//          frame_valid      one-cycle pulse when display updates
//          blanked          qualified blank interval in progress
//          blinking         a blank interval was seen recently
//          pat_err          one-cycle pulse, undecodable pattern
//          seq_err          one-cycle pulse, out-of-order or illegal digit select
module seven_segment_capture
   import seg_pkg::*;
#(
   parameter int unsigned BLANK_MIN     = 16,
   parameter int unsigned BLINK_TIMEOUT = 1000000,
   parameter int unsigned CNT_W         = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   seven_segment_capture_if.slave bus,
   output logic [23:0]            display,
   output logic                   frame_valid,
   output logic                   blanked,
   output logic                   blinking,
   output logic                   pat_err,
   output logic                   seq_err
);

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_MIN - 1);
   localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(BLINK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic [5:0]       pos_q;
   logic [7:0]       data_q;
   logic [2:0]       exp_q,         exp_d;
   logic [4:0][3:0]  shadow_q,      shadow_d;
   logic [CNT_W-1:0] blank_cnt_q,   blank_cnt_d;
   logic [CNT_W-1:0] tmo_q,         tmo_d;
   logic [23:0]      display_q,     display_d;
   logic             frame_valid_q, frame_valid_d;
   logic             blanked_q,     blanked_d;
   logic             blinking_q,    blinking_d;
   logic             pat_err_q,     pat_err_d;
   logic             seq_err_q,     seq_err_d;

   logic [2:0] pos_idx;
   logic       pos_valid;
   logic       pos_blank;
   logic [3:0] code;
   logic       code_invalid;

   seg_pattern_decode u_decode (
      .pat_i     (data_q),
      .code_o    (code),
      .invalid_o (code_invalid)
   );

   always_comb begin
      pos_idx   = 3'd0;
      pos_valid = 1'b1;
      case (pos_q)
         POS_D0:  pos_idx = 3'd0;
         POS_D1:  pos_idx = 3'd1;
         POS_D2:  pos_idx = 3'd2;
         POS_D3:  pos_idx = 3'd3;
         POS_D4:  pos_idx = 3'd4;
         POS_D5:  pos_idx = 3'd5;
         default: pos_valid = 1'b0;
      endcase
   end

   assign pos_blank = (pos_q == POS_OFF);

   always_comb begin
      exp_d         = exp_q;
      shadow_d      = shadow_q;
      blank_cnt_d   = blank_cnt_q;
      tmo_d         = tmo_q;
      display_d     = display_q;
      frame_valid_d = 1'b0;
      blanked_d     = blanked_q;
      blinking_d    = blinking_q;
      pat_err_d     = 1'b0;
      seq_err_d     = 1'b0;

      // Timeout only runs once the blank interval is over.
      if (blanked_q) begin
         tmo_d = '0;
      end else if (blinking_q) begin
         if (tmo_q == TMO_LAST) begin
            blinking_d = 1'b0;
            tmo_d      = '0;
         end else begin
            tmo_d = tmo_q + CNT_ONE;
         end
      end

      if (pos_valid) begin
         blank_cnt_d = '0;
         blanked_d   = 1'b0;
         pat_err_d   = code_invalid;
         if (pos_idx == exp_q) begin
            if (pos_idx == 3'd5) begin
               display_d     = {shadow_q[0], shadow_q[1], shadow_q[2],
                                shadow_q[3], shadow_q[4], code};
               frame_valid_d = 1'b1;
               exp_d         = 3'd0;
            end else begin
               for (int i = 0; i < 5; i++) begin
                  if (pos_idx == 3'(i)) shadow_d[i] = code;
               end
               exp_d = pos_idx + 3'd1;
            end
         end else begin
            seq_err_d = 1'b1;
            // A stray digit0 is the start of a new frame, not just noise.
            if (pos_idx == 3'd0) begin
               shadow_d[0] = code;
               exp_d       = 3'd1;
            end else begin
               exp_d = 3'd0;
            end
         end
      end else if (pos_blank) begin
         if (blank_cnt_q != '1) blank_cnt_d = blank_cnt_q + CNT_ONE;
         // Qualifying blank: aborts the partial frame and restarts the
         // blink timeout; overrides a timeout expiring on the same edge.
         if (blank_cnt_q == BLANK_LAST) begin
            blanked_d  = 1'b1;
            blinking_d = 1'b1;
            tmo_d      = '0;
            exp_d      = 3'd0;
         end
      end else begin
         seq_err_d = 1'b1;
         exp_d     = 3'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // Stage 1 resets to all-off so the first edge is a blank, not an illegal select.
         pos_q         <= POS_OFF;
         data_q        <= '0;
         exp_q         <= '0;
         shadow_q      <= '0;
         blank_cnt_q   <= '0;
         tmo_q         <= '0;
         display_q     <= '0;
         frame_valid_q <= 1'b0;
         blanked_q     <= 1'b0;
         blinking_q    <= 1'b0;
         pat_err_q     <= 1'b0;
         seq_err_q     <= 1'b0;
      end else begin
         pos_q         <= bus.fnd_pos;
         data_q        <= bus.fnd_data;
         exp_q         <= exp_d;
         shadow_q      <= shadow_d;
         blank_cnt_q   <= blank_cnt_d;
         tmo_q         <= tmo_d;
         display_q     <= display_d;
         frame_valid_q <= frame_valid_d;
         blanked_q     <= blanked_d;
         blinking_q    <= blinking_d;
         pat_err_q     <= pat_err_d;
         seq_err_q     <= seq_err_d;
      end
   end

   assign display     = display_q;
   assign frame_valid = frame_valid_q;
   assign blanked     = blanked_q;
   assign blinking    = blinking_q;
   assign pat_err     = pat_err_q;
   assign seq_err     = seq_err_q;

endmodule
